// File: rtl/mult_div_pkg.sv
// ============================================================================
// Module : mult_div_pkg
// Brief  : Opcodes, FSM states and helpers shared by the HI/LO mult/div unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_pkg;

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // True for the four opcodes that run through the iterative datapath.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == c_op_mult) || (op == c_op_multu) ||
               (op == c_op_div)  || (op == c_op_divu);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_core.sv
// ============================================================================
// Module : mult_div_core
// Brief  : Unsigned shift-add multiply / restoring divide datapath, one step per clock.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower
);

    // Multiply: upper = partial product, lower = remaining multiplier bits.
    // Divide  : upper = partial remainder, lower = dividend bits / quotient.
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    always_comb begin
        w_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shift = {r_upper, r_lower[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
        // Remainder stays below the divisor, so the difference fits in WIDTH bits.
        w_sub   = w_shift[WIDTH-1:0] - r_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upper <= '0;
            r_lower <= '0;
            r_b     <= '0;
        end else if (load) begin
            r_upper <= '0;
            r_lower <= a;
            r_b     <= b;
        end else if (step) begin
            if (!div_mode) begin
                r_upper <= w_sum[WIDTH:1];
                r_lower <= {w_sum[0], r_lower[WIDTH-1:1]};
            end else if (w_ge) begin
                r_upper <= w_sub;
                r_lower <= {r_lower[WIDTH-2:0], 1'b1};
            end else begin
                r_upper <= w_shift[WIDTH-1:0];
                r_lower <= {r_lower[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign upper = r_upper;
    assign lower = r_lower;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module : mult_div_unit
// Brief  : Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning architectural HI/LO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_mode;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;

    logic               w_load;
    logic               w_step;
    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_upper;
    logic [WIDTH-1:0]   w_lower;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_accept = start && (r_state == ST_IDLE) && is_iterative(op);
        w_signed = (op == c_op_mult) || (op == c_op_div);
        w_a_neg  = w_signed && rs_val[WIDTH-1];
        w_b_neg  = w_signed && rt_val[WIDTH-1];
        w_a_mag  = w_a_neg ? (~rs_val + 1'b1) : rs_val;
        w_b_mag  = w_b_neg ? (~rt_val + 1'b1) : rt_val;
        w_prod   = {w_upper, w_lower};
    end

    mult_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .step     (w_step),
        .div_mode (r_div_mode),
        .a        (w_a_mag),
        .b        (w_b_mag),
        .upper    (w_upper),
        .lower    (w_lower)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = ((op == c_op_mult) || (op == c_op_multu)) ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_mode <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (op == c_op_mthi)) begin
                        r_hi <= rs_val;
                    end
                    if (start && (op == c_op_mtlo)) begin
                        r_lo <= rs_val;
                    end
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_div_mode <= (op == c_op_div) || (op == c_op_divu);
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div0     <= (rt_val == '0);
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_div_mode) begin
                        // Divide by zero forces an all-ones quotient; the remainder
                        // path already reconstructs the original dividend.
                        r_lo <= r_div0    ? '1 : (r_neg_res ? (~w_lower + 1'b1) : w_lower);
                        r_hi <= r_neg_rem ? (~w_upper + 1'b1) : w_upper;
                    end else begin
                        {r_hi, r_lo} <= r_neg_res ? (~w_prod + 1'b1) : w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module : tb_mult_div_unit
// Brief  : Self-checking bench for mult_div_unit: arithmetic reference model plus directed vectors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic [2:0]  op     = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands seen at the accepting edge.
    function automatic void model_result(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, output logic [31:0] h,
                                         output logic [31:0] l);
        logic signed [63:0] sa, sb, p, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        h = '0;
        l = '0;
        case (o)
            3'd0: begin p = sa * sb; {h, l} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                case (op)
                    3'd4: m_hi = rs_val;
                    3'd5: m_lo = rs_val;
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        model_result(op, rs_val, rt_val, p_hi, p_lo);
                        m_cnt = 33;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("model_hi", hi, m_hi);
        check("model_lo", lo, m_lo);
        check("model_busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
        check("model_done", {31'd0, done}, {31'd0, m_done});
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_idle(output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) dc++;
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int bc, dc;
        issue(o, a, b);
        wait_idle(bc, dc);
        check({nm, "_busy_cycles"}, bc, 32'd33);
        check({nm, "_done_pulses"}, dc, 32'd1);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
    endtask

    initial begin
        int bc, dc;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_op("div_zero",  3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("mult_mix",  3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);

        // Back-to-back moves, then an undefined opcode that must change nothing.
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'h1234_5678;
        @(negedge clk);
        op = 3'd5; rs_val = 32'hCAFE_F00D;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        op = 3'd6; rs_val = 32'h5555_AAAA;
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("undef_hi", hi, 32'h1234_5678);
        check("undef_lo", lo, 32'hCAFE_F00D);
        check("undef_busy", {31'd0, busy}, 32'd0);

        // Move request arriving while busy is dropped.
        issue(3'd1, 32'd7, 32'd6);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc, dc);
        check("busy_mthi_done", dc, 32'd1);
        check("busy_mthi_hi", hi, 32'd0);
        check("busy_mthi_lo", lo, 32'd42);

        // Asynchronous reset in the middle of a divide.
        issue(3'd3, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_op("divu_after_rst", 3'd3, 32'd1000, 32'd3, 32'd1, 32'd333);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
